// File: rtl/i2c_pkg.sv
// Shared types and constants for the ADT7420 read scheduler.
// State encoding plus sensor register map.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } sched_state_t;

  localparam logic [7:0] ADT7420_TEMP_MSB = 8'h00;
  localparam logic [7:0] ADT7420_TEMP_LSB = 8'h01;
  localparam logic [7:0] ADT7420_ID       = 8'h0B;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_poll_timer.sv
// Free-running poll period counter.
// Emits a one-cycle tick each time the count wraps.
module i2c_poll_timer #(
  parameter int POLL_CYCLES = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW =
    (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_read_scheduler.sv
// Arbitrates periodic temperature polls and manual register
// reads onto a single I2C master, with retry and backoff.
module i2c_read_scheduler
  import i2c_pkg::*;
#(
  parameter int POLL_CYCLES    = 25_000_000,
  parameter int MAX_RETRY      = 2,
  parameter int BACKOFF_CYCLES = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        man_req,
  input  logic [7:0]  man_addr,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_error,
  input  logic [7:0]  i2c_rdata,
  output logic        i2c_start,
  output logic [7:0]  i2c_reg_addr,
  output logic [15:0] temp_raw,
  output logic        temp_valid,
  output logic [7:0]  man_data,
  output logic        man_valid,
  output logic        man_drop,
  output logic        sched_busy,
  output logic [7:0]  err_count
);

  localparam int RW =
    (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int BW =
    (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);
  localparam logic [BW-1:0] BLAST = BW'(BACKOFF_CYCLES - 1);

  sched_state_t  state;
  logic [1:0]    rst_sync;
  logic          run;
  logic          tick;
  logic          poll_pend;
  logic          man_pend;
  logic [7:0]    man_addr_q;
  logic          is_man;
  logic          is_lsb;
  logic [7:0]    msb_q;
  logic [RW-1:0] retry;
  logic [BW-1:0] bo_cnt;
  logic          take_man;
  logic          take_poll;

  // FSM may only leave IDLE once release has passed two flops
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  i2c_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_timer (
    .clk  (CLK100MHZ),
    .rst_n(CPU_RESETN),
    .tick (tick)
  );

  assign take_man  = (state == IDLE) && run && man_pend;
  assign take_poll = (state == IDLE) && run && !man_pend
                   && poll_pend;

  assign i2c_start  = (state == ISSUE) && !i2c_busy;
  assign sched_busy = (state != IDLE);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state        <= IDLE;
      poll_pend    <= 1'b0;
      man_pend     <= 1'b0;
      man_addr_q   <= '0;
      is_man       <= 1'b0;
      is_lsb       <= 1'b0;
      msb_q        <= '0;
      retry        <= '0;
      bo_cnt       <= '0;
      i2c_reg_addr <= '0;
      temp_raw     <= '0;
      temp_valid   <= 1'b0;
      man_data     <= '0;
      man_valid    <= 1'b0;
      man_drop     <= 1'b0;
      err_count    <= '0;
    end else begin
      temp_valid <= 1'b0;
      man_valid  <= 1'b0;
      man_drop   <= 1'b0;

      if (tick)           poll_pend <= 1'b1;
      else if (take_poll) poll_pend <= 1'b0;

      // a slot freed in the same cycle can accept the new request
      if (man_req) begin
        if (man_pend && !take_man) begin
          man_drop <= 1'b1;
        end else begin
          man_pend   <= 1'b1;
          man_addr_q <= man_addr;
        end
      end else if (take_man) begin
        man_pend <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (take_man) begin
            i2c_reg_addr <= man_addr_q;
            is_man       <= 1'b1;
            is_lsb       <= 1'b0;
            retry        <= '0;
            state        <= ISSUE;
          end else if (take_poll) begin
            i2c_reg_addr <= ADT7420_TEMP_MSB;
            is_man       <= 1'b0;
            is_lsb       <= 1'b0;
            retry        <= '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!i2c_busy) state <= WAIT;
        end
        WAIT: begin
          if (i2c_error) begin
            if (retry < RMAX) begin
              retry  <= retry + 1'b1;
              bo_cnt <= '0;
              state  <= BACKOFF;
            end else begin
              err_count <= sat_inc8(err_count);
              state     <= IDLE;
            end
          end else if (i2c_done) begin
            if (is_man) begin
              man_data  <= i2c_rdata;
              man_valid <= 1'b1;
              state     <= IDLE;
            end else if (!is_lsb) begin
              msb_q        <= i2c_rdata;
              is_lsb       <= 1'b1;
              i2c_reg_addr <= ADT7420_TEMP_LSB;
              retry        <= '0;
              state        <= ISSUE;
            end else begin
              temp_raw   <= {msb_q, i2c_rdata};
              temp_valid <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        BACKOFF: begin
          if (bo_cnt == BLAST) state <= ISSUE;
          else                 bo_cnt <= bo_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_read_scheduler.sv
// Scoreboard bench for i2c_read_scheduler with a simple
// I2C master model replaying scripted responses.
module tb_i2c_read_scheduler;
  import i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        man_req;
  logic [7:0]  man_addr;
  logic        i2c_busy;
  logic        i2c_done;
  logic        i2c_error;
  logic [7:0]  i2c_rdata;
  logic        i2c_start;
  logic [7:0]  i2c_reg_addr;
  logic [15:0] temp_raw;
  logic        temp_valid;
  logic [7:0]  man_data;
  logic        man_valid;
  logic        man_drop;
  logic        sched_busy;
  logic [7:0]  err_count;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [7:0]  exp_start[$];
  logic [15:0] exp_temp[$];
  logic [7:0]  exp_man[$];
  int          start_cyc[$];
  int checks = 0;
  int failures = 0;
  int drops = 0;
  int temps = 0;
  int cyc = 0;

  i2c_read_scheduler #(
    .POLL_CYCLES(1000),
    .MAX_RETRY(2),
    .BACKOFF_CYCLES(20)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .man_req     (man_req),
    .man_addr    (man_addr),
    .i2c_busy    (i2c_busy),
    .i2c_done    (i2c_done),
    .i2c_error   (i2c_error),
    .i2c_rdata   (i2c_rdata),
    .i2c_start   (i2c_start),
    .i2c_reg_addr(i2c_reg_addr),
    .temp_raw    (temp_raw),
    .temp_valid  (temp_valid),
    .man_data    (man_data),
    .man_valid   (man_valid),
    .man_drop    (man_drop),
    .sched_busy  (sched_busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm,
                            input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", nm, act);
  endtask

  // monitor: compare every DUT output event with the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (i2c_start) begin
        start_cyc.push_back(cyc);
        if (exp_start.size() == 0)
          unexpected("start_addr", 64'(i2c_reg_addr));
        else
          check("start_addr", 64'(i2c_reg_addr),
                64'(exp_start.pop_front()));
      end
      if (temp_valid) begin
        temps++;
        if (exp_temp.size() == 0)
          unexpected("temp_raw", 64'(temp_raw));
        else
          check("temp_raw", 64'(temp_raw),
                64'(exp_temp.pop_front()));
      end
      if (man_valid) begin
        if (exp_man.size() == 0)
          unexpected("man_data", 64'(man_data));
        else
          check("man_data", 64'(man_data),
                64'(exp_man.pop_front()));
      end
      if (man_drop) drops++;
    end
  end

  // I2C master model: fixed latency, scripted done/error
  initial begin
    resp_t r;
    i2c_busy  = 1'b0;
    i2c_done  = 1'b0;
    i2c_error = 1'b0;
    i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && i2c_start) begin
        if (rq.size() == 0) begin
          unexpected("model_resp", 64'(i2c_reg_addr));
          r = '0;
        end else begin
          r = rq.pop_front();
        end
        @(posedge clk); #1;
        i2c_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        i2c_busy  = 1'b0;
        i2c_rdata = r.data;
        i2c_done  = !r.err;
        i2c_error = r.err;
        @(posedge clk); #1;
        i2c_done  = 1'b0;
        i2c_error = 1'b0;
      end
    end
  end

  task automatic pulse_man(input logic [7:0] a);
    @(posedge clk); #1;
    man_req  = 1'b1;
    man_addr = a;
    @(posedge clk); #1;
    man_req  = 1'b0;
  endtask

  task automatic wait_start(input logic [7:0] a,
                            input int max,
                            output int at);
    bit hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      if (i2c_start && i2c_reg_addr == a) begin
        hit = 1'b1;
        at  = cyc;
      end
    end
    check("wait_start", 64'(hit), 64'd1);
  endtask

  task automatic wait_quiet(input int max, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < max && !hit; i++) begin
      @(negedge clk);
      if (!sched_busy && exp_start.size() == 0 &&
          exp_temp.size() == 0 && exp_man.size() == 0 &&
          rq.size() == 0)
        hit = 1'b1;
    end
    check(nm, 64'(hit), 64'd1);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({i2c_start, i2c_reg_addr, temp_raw,
                temp_valid, man_data, man_valid,
                man_drop, sched_busy, err_count});
  endfunction

  initial begin
    int at;
    int rel;
    int n0;
    rst_n    = 1'b1;
    man_req  = 1'b0;
    man_addr = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // manual read of the ID register
    rq.push_back('{err: 1'b0, data: 8'hCB});
    exp_start.push_back(ADT7420_ID);
    exp_man.push_back(8'hCB);
    pulse_man(ADT7420_ID);
    wait_quiet(100, "man_id_done");

    // two requests while busy: one pends, one drops
    rq.push_back('{err: 1'b0, data: 8'h5A});
    rq.push_back('{err: 1'b0, data: 8'hA5});
    exp_start.push_back(8'h20);
    exp_start.push_back(8'h21);
    exp_man.push_back(8'h5A);
    exp_man.push_back(8'hA5);
    pulse_man(8'h20);
    repeat (3) @(posedge clk);
    pulse_man(8'h21);
    pulse_man(8'h22);
    wait_quiet(200, "man_drop_done");
    check("man_drop_count", 64'(drops), 64'd1);

    // poll pair with a manual request arriving mid-pair
    rq.push_back('{err: 1'b0, data: 8'h0C});
    rq.push_back('{err: 1'b0, data: 8'h80});
    rq.push_back('{err: 1'b0, data: 8'h55});
    exp_start.push_back(ADT7420_TEMP_MSB);
    exp_start.push_back(ADT7420_TEMP_LSB);
    exp_start.push_back(8'h0B);
    exp_temp.push_back(16'h0C80);
    exp_man.push_back(8'h55);
    wait_start(ADT7420_TEMP_MSB, 1500, at);
    pulse_man(8'h0B);
    wait_quiet(200, "poll_done");
    check("temp_count", 64'(temps), 64'd1);

    // MSB fails once, LSB fails three times: pair abandoned
    n0 = start_cyc.size();
    rq.push_back('{err: 1'b1, data: 8'h00});
    rq.push_back('{err: 1'b0, data: 8'h11});
    rq.push_back('{err: 1'b1, data: 8'h00});
    rq.push_back('{err: 1'b1, data: 8'h00});
    rq.push_back('{err: 1'b1, data: 8'h00});
    exp_start.push_back(ADT7420_TEMP_MSB);
    exp_start.push_back(ADT7420_TEMP_MSB);
    exp_start.push_back(ADT7420_TEMP_LSB);
    exp_start.push_back(ADT7420_TEMP_LSB);
    exp_start.push_back(ADT7420_TEMP_LSB);
    wait_quiet(1500, "retry_done");
    check("err_count", 64'(err_count), 64'd1);
    check("idle_after_abandon", 64'(sched_busy), 64'd0);
    check("temp_count_abandon", 64'(temps), 64'd1);
    check("retry_starts", 64'(start_cyc.size() - n0), 64'd5);
    if (start_cyc.size() - n0 == 5) begin
      check("retry_gap1",
            64'(start_cyc[n0+3] - start_cyc[n0+2] >= 25),
            64'd1);
      check("retry_gap2",
            64'(start_cyc[n0+4] - start_cyc[n0+3] >= 25),
            64'd1);
    end

    // reset in WAIT
    rq.push_back('{err: 1'b0, data: 8'h33});
    exp_start.push_back(ADT7420_TEMP_MSB);
    wait_start(ADT7420_TEMP_MSB, 1500, at);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_wait_outs", all_outs(), 64'd0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    rq.push_back('{err: 1'b0, data: 8'h12});
    rq.push_back('{err: 1'b0, data: 8'h34});
    exp_start.push_back(ADT7420_TEMP_MSB);
    exp_start.push_back(ADT7420_TEMP_LSB);
    exp_temp.push_back(16'h1234);
    check("err_after_reset", 64'(err_count), 64'd0);
    wait_start(ADT7420_TEMP_MSB, 1100, at);
    check("poll_after_reset",
          64'((at - rel) >= 995 && (at - rel) <= 1010),
          64'd1);
    wait_quiet(200, "final_done");
    check("temp_count_end", 64'(temps), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks + 1, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_read_scheduler.md
I2C_READ_SCHEDULER -- requirements
Module: i2c_read_scheduler

Interface
REQ-001 Parameter POLL_CYCLES, default 25_000_000, is the auto-poll period in clock cycles (250 ms at 100 MHz).
REQ-002 Parameter MAX_RETRY, default 2, is the number of retries after a failed transaction.
REQ-003 Parameter BACKOFF_CYCLES, default 1000, is the idle gap before each retry.
REQ-004 Port CLK100MHZ  in  1  single system clock; all logic is on its rising edge.
REQ-005 Port CPU_RESETN  in  1  reset, asynchronous and active-low.
REQ-006 Port man_req  in  1  single-cycle pulse requesting a manual register read.
REQ-007 Port man_addr  in  8  register address for a manual read; sampled on man_req.
REQ-008 Port i2c_busy  in  1  the I2C master is mid-transaction.
REQ-009 Port i2c_done  in  1  single-cycle pulse: the read completed OK.
REQ-010 Port i2c_error  in  1  single-cycle pulse: NACK or bus fault.
REQ-011 Port i2c_rdata  in  8  read byte; valid in the i2c_done cycle.
REQ-012 Port i2c_start  out  1  single-cycle pulse launching a read.
REQ-013 Port i2c_reg_addr  out  8  register pointer for the current read.
REQ-014 Port temp_raw  out  16  last complete {MSB,LSB} temperature pair.
REQ-015 Port temp_valid  out  1  single-cycle pulse when temp_raw updates.
REQ-016 Port man_data  out  8  result of the last manual read.
REQ-017 Port man_valid  out  1  single-cycle pulse when man_data updates.
REQ-018 Port man_drop  out  1  single-cycle pulse when a manual request is discarded.
REQ-019 Port sched_busy  out  1  the FSM is not in IDLE.
REQ-020 Port err_count  out  8  count of abandoned transactions; saturates at 255.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and BACKOFF.
REQ-022 Poll timer SHALL count 0..POLL_CYCLES-1; at wrap it SHALL set poll_pending, with no double-set while already pending.
REQ-023 In IDLE with manual pending, the manual read SHALL be selected; otherwise, with poll_pending, the poll pair (0x00 then 0x01) SHALL be selected; otherwise the FSM stays in IDLE.
REQ-024 A poll pair SHALL be atomic; a manual request SHALL wait until the LSB read resolves.
REQ-025 Manual pending SHALL be one entry deep; a man_req while an entry is already pending SHALL be dropped and SHALL pulse man_drop.
REQ-026 ISSUE SHALL assert i2c_start for exactly one cycle, only when i2c_busy=0, then enter WAIT; while i2c_busy=1 it SHALL hold in ISSUE.
REQ-027 i2c_reg_addr SHALL be stable from ISSUE until the done/error cycle.
REQ-028 In WAIT, i2c_done SHALL capture i2c_rdata: MSB into temp_raw[15:8] (held internally), LSB completes the pair, manual into man_data.
REQ-029 temp_raw and temp_valid SHALL update together one cycle after the LSB i2c_done; man_valid likewise one cycle after the manual i2c_done.
REQ-030 If i2c_done and i2c_error occur in the same cycle, error SHALL win.
REQ-031 On i2c_error with retries used < MAX_RETRY, the FSM SHALL go to BACKOFF for BACKOFF_CYCLES, then to ISSUE with the same address.
REQ-032 On an error with retries exhausted, the FSM SHALL abandon the read, increment err_count, and return to IDLE; for a poll pair the whole pair is abandoned, with no temp_valid.
REQ-033 The retry counter SHALL clear for each new read, including the LSB of a pair.
REQ-034 The poll timer SHALL free-run during transactions; a wrap during a pair leaves poll_pending set for the next pair.

Reset
REQ-035 Assertion of CPU_RESETN low SHALL, at any time including mid-transaction, force IDLE and clear both pending flags, the timer, the retry count and err_count.
REQ-036 During reset, all outputs SHALL be 0, including temp_raw and man_data, with no i2c_start issued.
REQ-037 Reset release SHALL be synchronised by two flops before the FSM leaves IDLE.

Structure
REQ-038 Shared package i2c_pkg SHALL hold the FSM state enum and the constants ADT7420_TEMP_MSB=8'h00, ADT7420_TEMP_LSB=8'h01 and ADT7420_ID=8'h0B.
REQ-039 The poll timer SHALL be the sub-module i2c_poll_timer (parameter POLL_CYCLES, output tick).

Verification (POLL_CYCLES=1000, BACKOFF_CYCLES=20, I2C master model)
REQ-040 Scenario: tick, model returns 0x0C then 0x80 -> exactly one temp_valid with temp_raw=16'h0C80, and starts to 0x00 then 0x01.
REQ-041 Scenario: man_req with man_addr=0x0B, model returns 0xCB -> man_valid with man_data=0xCB, and i2c_start carries i2c_reg_addr=0x0B.
REQ-042 Scenario: man_req during a poll MSB read -> the manual start follows the LSB done, never between the pair reads.
REQ-043 Scenario: two man_req while busy -> one man_drop pulse and one manual read.
REQ-044 Scenario: model errors 3 times on the LSB -> 2 retries, each 20+ cycles apart, then err_count=1, no temp_valid, FSM in IDLE.
REQ-045 Scenario: CPU_RESETN low in WAIT -> all outputs 0 immediately, and the next poll starts 1000 cycles after release.
